// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arb_pkg
// Purpose  : Shared types and default widths for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 11;
    localparam int DATA_W_DEFAULT = 16;

    // Who owns the read data coming back from memory in the next cycle
    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_CPU  = 2'd1,
        RET_EXT  = 2'd2
    } ret_owner_e;

endpackage : data_mem_arb_pkg
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_wait_counter
// Purpose  : Saturating count of cycles an external request has been denied.
// Revision : 1.0 - initial release
// ============================================================================
module arb_wait_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] sat_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment; increment stops at the saturation value
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < sat_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : arb_wait_counter
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Two-requester (CPU / external) arbiter for a single-port data
//            memory with one-cycle read latency and starvation protection.
//            Optional macro DATA_MEM_ARB_WRITE_PROTECT_EN rejects external
//            writes at or above PROTECT_BASE.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEFAULT,
    parameter int                DATA_W       = DATA_W_DEFAULT,
    parameter int                STARVE_MAX   = 4,
    parameter logic [ADDR_W-1:0] PROTECT_BASE = 11'h700
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CpuRd,
    input  logic              CpuWr,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic [DATA_W-1:0] CpuRData,
    output logic              CpuHold,
    input  logic              ExtReq,
    input  logic              ExtWe,
    input  logic [ADDR_W-1:0] ExtAddr,
    input  logic [DATA_W-1:0] ExtWData,
    output logic              ExtGnt,
    output logic [DATA_W-1:0] ExtRData,
    output logic              ExtRValid,
    output logic              ExtErr,
    output logic              MemRd,
    output logic              MemWr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic             w_cpu_act;
    logic             w_cpu_rd;
    logic             w_starved;
    logic             w_ext_win;
    logic             w_cpu_win;
    logic             w_ext_blocked;
    logic             w_route_cpu;
    logic             w_route_ext;
    logic [CNT_W-1:0] w_wait_cnt;
    ret_owner_e       owner_q;
    ret_owner_e       owner_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;

    // Arbitration decision; nothing is granted while reset is asserted
    assign w_cpu_act = CpuRd | CpuWr;
    assign w_cpu_rd  = CpuRd & ~CpuWr;
    assign w_starved = (w_wait_cnt == CNT_W'(STARVE_MAX));
    assign w_ext_win = ~Reset & ExtReq & (~w_cpu_act | w_starved);
    assign w_cpu_win = ~Reset & w_cpu_act & ~w_ext_win;

    assign ExtGnt  = w_ext_win;
    assign CpuHold = w_cpu_act & w_ext_win;

    arb_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk     (Clock),
        .rst     (Reset),
        .inc_i   (ExtReq & ~w_ext_win),
        .clr_i   (w_ext_win | ~ExtReq),
        .sat_i   (CNT_W'(STARVE_MAX)),
        .count_o (w_wait_cnt)
    );

`ifdef DATA_MEM_ARB_WRITE_PROTECT_EN
    logic ext_err_q;

    assign w_ext_blocked = w_ext_win & ExtWe & (ExtAddr >= PROTECT_BASE);

    // Reject pulse appears the cycle after a blocked external write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ext_err_q <= 1'b0;
        end else begin
            ext_err_q <= w_ext_blocked;
        end
    end

    assign ExtErr = ext_err_q;
`else
    logic w_unused_protect;

    assign w_unused_protect = &{1'b0, PROTECT_BASE};
    assign w_ext_blocked    = 1'b0;
    assign ExtErr           = 1'b0;
`endif

    // Memory strobe/address/data mux of the winning requester
    always_comb begin
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        MemAddr  = '0;
        MemWData = '0;
        if (w_ext_win) begin
            MemRd    = ~ExtWe;
            MemWr    = ExtWe & ~w_ext_blocked;
            MemAddr  = ExtAddr;
            MemWData = ExtWData;
        end else if (w_cpu_win) begin
            MemRd    = w_cpu_rd;
            MemWr    = CpuWr;
            MemAddr  = CpuAddr;
            MemWData = CpuWData;
        end
    end

    // Owner of the read issued this cycle; writes and idle cycles return nothing
    always_comb begin
        owner_d = RET_NONE;
        if (w_ext_win && !ExtWe) begin
            owner_d = RET_EXT;
        end else if (w_cpu_win && w_cpu_rd) begin
            owner_d = RET_CPU;
        end
    end

    // Read data from a read issued before reset is dropped while reset is high
    assign w_route_cpu = (owner_q == RET_CPU) & ~Reset;
    assign w_route_ext = (owner_q == RET_EXT) & ~Reset;

    // Return-owner state and the hold registers for the last routed data
    always_ff @(posedge Clock) begin
        if (Reset) begin
            owner_q     <= RET_NONE;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (w_route_cpu) begin
                cpu_rdata_q <= MemRData;
            end
            if (w_route_ext) begin
                ext_rdata_q <= MemRData;
            end
        end
    end

    assign CpuRData  = w_route_cpu ? MemRData : cpu_rdata_q;
    assign ExtRData  = w_route_ext ? MemRData : ext_rdata_q;
    assign ExtRValid = w_route_ext;

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Directed plus randomized checks of data_mem_arbiter against a
//            cycle-level reference model and a bench-side memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int SM = 4;
`ifdef DATA_MEM_ARB_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic          CpuRd, CpuWr, ExtReq, ExtWe;
    logic [AW-1:0] CpuAddr, ExtAddr;
    logic [DW-1:0] CpuWData, ExtWData;
    logic [DW-1:0] CpuRData, ExtRData;
    logic          CpuHold, ExtGnt, ExtRValid, ExtErr, MemRd, MemWr;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] MemRData;

    always #5 Clock = ~Clock;

    data_mem_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .STARVE_MAX (SM), .PROTECT_BASE (11'h700)
    ) dut (
        .Clock (Clock), .Reset (Reset),
        .CpuRd (CpuRd), .CpuWr (CpuWr), .CpuAddr (CpuAddr), .CpuWData (CpuWData),
        .CpuRData (CpuRData), .CpuHold (CpuHold),
        .ExtReq (ExtReq), .ExtWe (ExtWe), .ExtAddr (ExtAddr), .ExtWData (ExtWData),
        .ExtGnt (ExtGnt), .ExtRData (ExtRData), .ExtRValid (ExtRValid), .ExtErr (ExtErr),
        .MemRd (MemRd), .MemWr (MemWr), .MemAddr (MemAddr), .MemWData (MemWData),
        .MemRData (MemRData)
    );

    // Bench memory driven by the DUT strobes, one-cycle read latency
    logic [DW-1:0] mem [0:2047];
    always @(posedge Clock) begin
        if (MemWr) mem[MemAddr] <= MemWData;
        if (MemRd) MemRData <= mem[MemAddr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:2047];
    int            m_wait;
    int            m_prev;          // 0 none, 1 cpu read pending, 2 ext read pending
    logic [DW-1:0] m_prev_data, m_cpu_last, m_ext_last;
    bit            m_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    logic          obs_gnt, obs_hold, obs_rd, obs_wr, obs_rv, obs_err;
    logic [DW-1:0] obs_crd, obs_erd;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic step();
        bit cpu_act, cpu_rd, ext_win, cpu_win, prot;
        bit e_rd, e_wr, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_crd, e_erd;
        @(negedge Clock);
        cpu_act = CpuRd || CpuWr;
        cpu_rd  = CpuRd && !CpuWr;
        ext_win = !Reset && ExtReq && (!cpu_act || m_wait == SM);
        cpu_win = !Reset && cpu_act && !ext_win;
        prot    = PROT_EN && ExtWe && (ExtAddr >= 11'h700);
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
        if (ext_win) begin
            e_rd = !ExtWe; e_wr = ExtWe && !prot; e_addr = ExtAddr; e_wd = ExtWData;
        end else if (cpu_win) begin
            e_rd = cpu_rd; e_wr = CpuWr; e_addr = CpuAddr; e_wd = CpuWData;
        end
        e_rv  = !Reset && m_prev == 2;
        e_erd = e_rv ? m_prev_data : m_ext_last;
        e_crd = (!Reset && m_prev == 1) ? m_prev_data : m_cpu_last;
        obs_gnt = ExtGnt; obs_hold = CpuHold; obs_rd = MemRd; obs_wr = MemWr;
        obs_rv = ExtRValid; obs_err = ExtErr; obs_crd = CpuRData; obs_erd = ExtRData;
        if (chk_en) begin
            chk_eq("gnt", obs_gnt, ext_win);
            chk_eq("hold", obs_hold, ext_win && cpu_act);
            chk_eq("memrd", obs_rd, e_rd);
            chk_eq("memwr", obs_wr, e_wr);
            if (e_rd || e_wr) chk_eq("memaddr", MemAddr, e_addr);
            if (e_wr) chk_eq("memwdata", MemWData, e_wd);
            chk_eq("rvalid", obs_rv, e_rv);
            chk_eq("extrdata", obs_erd, e_erd);
            chk_eq("cpurdata", obs_crd, e_crd);
            chk_eq("exterr", obs_err, m_err);
        end
        @(posedge Clock);
        if (Reset) begin
            m_wait = 0; m_prev = 0; m_cpu_last = '0; m_ext_last = '0; m_err = 1'b0;
        end else begin
            if (m_prev == 1) m_cpu_last = m_prev_data;
            if (m_prev == 2) m_ext_last = m_prev_data;
            m_err  = ext_win && prot;
            m_prev = (ext_win && !ExtWe) ? 2 : ((cpu_win && cpu_rd) ? 1 : 0);
            if (e_rd) m_prev_data = ref_mem[e_addr];
            if (e_wr) ref_mem[e_addr] = e_wd;
            m_wait = (ExtReq && !ext_win) ? ((m_wait < SM) ? m_wait + 1 : SM) : 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        CpuRd = 0; CpuWr = 0; CpuAddr = '0; CpuWData = '0;
        ExtReq = 0; ExtWe = 0; ExtAddr = '0; ExtWData = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return AW'(32'h700 + $urandom_range(0, 15));
        return AW'($urandom_range(0, 31));
    endfunction

    logic [DW-1:0] v1, v2, orig700;
    bit            gnt_log [0:5];
    bit            hold_log [0:5];
    bit            ext_busy;

    initial begin
        for (int a = 0; a < 2048; a++) begin
            v1 = DW'($urandom);
            mem[a] = v1; ref_mem[a] = v1;
        end
        mem[11'h010] = 16'h1234; ref_mem[11'h010] = 16'h1234;
        m_wait = 0; m_prev = 0; m_prev_data = '0; m_cpu_last = '0; m_ext_last = '0; m_err = 0;
        idle_inputs();
        Reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk_eq("rst_cpurdata", obs_crd, 16'h0);
        chk_eq("rst_extrdata", obs_erd, 16'h0);
        chk_eq("rst_rvalid", obs_rv, 1'b0);
        chk_eq("rst_exterr", obs_err, 1'b0);

        // External read with CPU idle
        ExtReq = 1; ExtWe = 0; ExtAddr = 11'h010;
        step();
        chk_eq("r23_gnt", obs_gnt, 1'b1);
        idle_inputs();
        step();
        chk_eq("r23_rvalid", obs_rv, 1'b1);
        chk_eq("r23_rdata", obs_erd, 16'h1234);

        // Starvation: CPU reads every cycle, external request held
        for (int i = 0; i < 6; i++) begin
            CpuRd = 1; CpuAddr = AW'(i);
            if (i == 0) begin ExtReq = 1; ExtWe = 0; ExtAddr = 11'h003; end
            step();
            gnt_log[i] = obs_gnt; hold_log[i] = obs_hold;
            if (obs_gnt) ExtReq = 0;
        end
        for (int i = 0; i < 4; i++) chk_eq("r24_cpu_wins", gnt_log[i], 1'b0);
        chk_eq("r24_ext_gnt4", gnt_log[4], 1'b1);
        chk_eq("r24_hold4", hold_log[4], 1'b1);
        chk_eq("r24_gnt5", gnt_log[5], 1'b0);
        chk_eq("r24_hold5", hold_log[5], 1'b0);
        idle_inputs();
        step();

        // Interleaved CPU then external reads
        v1 = ref_mem[1]; v2 = ref_mem[2];
        CpuRd = 1; CpuAddr = 11'h001;
        step();
        idle_inputs(); ExtReq = 1; ExtWe = 0; ExtAddr = 11'h002;
        step();
        chk_eq("r25_cpu_data", obs_crd, v1);
        chk_eq("r25_no_ext", obs_rv, 1'b0);
        idle_inputs();
        step();
        chk_eq("r25_ext_data", obs_erd, v2);
        chk_eq("r25_cpu_hold", obs_crd, v1);

        // Read+write together is a write
        CpuRd = 1; CpuWr = 1; CpuAddr = 11'h005; CpuWData = 16'hBEEF;
        step();
        chk_eq("r26_memwr", obs_wr, 1'b1);
        chk_eq("r26_memrd", obs_rd, 1'b0);
        idle_inputs();
        step();
        chk_eq("r26_mem", mem[5], 16'hBEEF);

        // Reset right after an external read grant
        ExtReq = 1; ExtWe = 0; ExtAddr = 11'h010;
        step();
        chk_eq("r27_gnt", obs_gnt, 1'b1);
        idle_inputs(); Reset = 1;
        step();
        chk_eq("r27_rvalid_in_rst", obs_rv, 1'b0);
        Reset = 0;
        step();
        chk_eq("r27_rvalid", obs_rv, 1'b0);
        chk_eq("r27_extrdata", obs_erd, 16'h0);
        chk_eq("r27_cpurdata", obs_crd, 16'h0);
        chk_eq("r27_exterr", obs_err, 1'b0);

        // External write into the protected region
        orig700 = ref_mem[11'h700];
        ExtReq = 1; ExtWe = 1; ExtAddr = 11'h700; ExtWData = 16'h00FF;
        step();
        chk_eq("r28_gnt", obs_gnt, 1'b1);
        chk_eq("r28_memwr", obs_wr, !PROT_EN);
        idle_inputs();
        step();
        chk_eq("r28_err", obs_err, PROT_EN);
        chk_eq("r28_mem", mem[11'h700], PROT_EN ? orig700 : 16'h00FF);

        // Randomized traffic with a well-behaved external requester
        ext_busy = 1'b0;
        for (int c = 0; c < 800; c++) begin
            Reset = ($urandom_range(0, 80) == 0);
            if (!ext_busy) begin
                ExtReq   = ($urandom_range(0, 2) != 0);
                ExtWe    = $urandom_range(0, 1);
                ExtAddr  = rnd_addr();
                ExtWData = DW'($urandom);
                ext_busy = ExtReq;
            end
            CpuRd    = ($urandom_range(0, 3) != 0);
            CpuWr    = ($urandom_range(0, 3) == 0);
            CpuAddr  = rnd_addr();
            CpuWData = DW'($urandom);
            step();
            if (obs_gnt) ext_busy = 1'b0;
        end
        idle_inputs(); Reset = 0;
        step();
        for (int a = 0; a < 32; a++) chk_eq("final_mem_lo", mem[a], ref_mem[a]);
        for (int a = 0; a < 16; a++) chk_eq("final_mem_hi", mem[11'h700 + a], ref_mem[11'h700 + a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_mem_arbiter
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The module SHALL provide parameter ADDR_W, default 11, memory word-address width.
REQ-002 The module SHALL provide parameter DATA_W, default 16, memory data width.
REQ-003 The module SHALL provide parameter STARVE_MAX, default 4, the maximum number of consecutive CPU-won cycles while an external request is pending.
REQ-004 The module SHALL provide parameter PROTECT_BASE, default 11'h700, the lowest write-protected address.
REQ-005 The ports SHALL be:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- CpuRd  in  1  CPU read strobe.
- CpuWr  in  1  CPU write strobe.
- CpuAddr  in  ADDR_W  CPU address.
- CpuWData  in  DATA_W  CPU write data.
- CpuRData  out  DATA_W  read data returned to the CPU.
- CpuHold  out  1  CPU clock-enable hold; the CPU does not advance while high.
- ExtReq  in  1  external (loader/debug) request.
- ExtWe  in  1  external write enable; 0 = read.
- ExtAddr  in  ADDR_W  external address.
- ExtWData  in  DATA_W  external write data.
- ExtGnt  out  1  external grant, one-cycle pulse.
- ExtRData  out  DATA_W  external read data.
- ExtRValid  out  1  ExtRData valid, one-cycle pulse.
- ExtErr  out  1  protected-write reject pulse (see REQ-019).
- MemRd, MemWr  out  1  memory strobes.
- MemAddr  out  ADDR_W  memory address.
- MemWData  out  DATA_W  memory write data.
- MemRData  in  DATA_W  memory read data, valid one cycle after MemRd.

Function
REQ-006 The arbiter SHALL issue at most one memory access per cycle; Mem* outputs are a combinational mux of the winning requester.
REQ-007 The CPU SHALL be active when CpuRd or CpuWr is high; CpuRd and CpuWr both high SHALL be treated as a write only.
REQ-008 If ExtReq is high and the CPU is inactive, Ext SHALL win that cycle.
REQ-009 If both are active, the CPU SHALL win unless WaitCnt == STARVE_MAX, in which case Ext SHALL win and CpuHold SHALL be high that cycle.
REQ-010 WaitCnt SHALL increment on every cycle that ExtReq is high and Ext loses, saturate at STARVE_MAX, and clear on any cycle in which ExtGnt is high or ExtReq is low.
REQ-011 ExtGnt SHALL be high exactly in the cycles in which Ext wins; the requester SHALL hold ExtReq/ExtWe/ExtAddr/ExtWData stable until it samples ExtGnt high.
REQ-012 CpuHold SHALL be low in every cycle that the CPU is inactive or the CPU wins.
REQ-013 A registered return-owner state {RET_NONE, RET_CPU, RET_EXT} SHALL record the owner of each read; the next cycle routes MemRData to CpuRData (RET_CPU) or to ExtRData with ExtRValid=1 (RET_EXT); writes and idle cycles load RET_NONE.
REQ-014 Read latency SHALL be one cycle for both requesters; back-to-back reads SHALL be allowed every cycle.
REQ-015 CpuRData and ExtRData SHALL hold their last routed value while not updated.

Reset
REQ-016 While Reset is high at a rising edge: WaitCnt=0, owner=RET_NONE, CpuRData=0, ExtRData=0, ExtRValid=0, ExtErr=0.
REQ-017 During reset cycles MemRd, MemWr, ExtGnt and CpuHold SHALL be 0; a read issued the cycle before reset asserts SHALL NOT produce ExtRValid.

Configuration
REQ-018 The macro DATA_MEM_ARB_WRITE_PROTECT_EN SHALL select the write-protect feature.
REQ-019 With the macro defined, a granted Ext write with ExtAddr >= PROTECT_BASE SHALL keep MemWr low, and ExtErr SHALL pulse the following cycle; CPU writes SHALL be unaffected.
REQ-020 Without the macro, all Ext writes SHALL reach memory, and ExtErr SHALL be tied to 0.

Structure
REQ-021 The shared package data_mem_arb_pkg SHALL hold the return-owner enum and the default values of ADDR_W and DATA_W.
REQ-022 The starvation counter SHALL be a sub-module, arb_wait_counter (inputs: increment, clear, saturation value; output: count).

Verification
REQ-023 Ext read with the CPU idle: ExtReq=1, ExtAddr=11'h010, memory[0x010]=16'h1234. Required: ExtGnt the same cycle, ExtRValid=1 and ExtRData=16'h1234 the next cycle.
REQ-024 Contention: CPU reads every cycle and ExtReq is held with STARVE_MAX=4. Required: the CPU wins cycles 0-3, Ext wins cycle 4 with CpuHold=1, and the CPU resumes in cycle 5.
REQ-025 Interleaved reads: CPU reads 0x001, then Ext reads 0x002 in the next cycle. Required: CpuRData gets mem[0x001] and ExtRData gets mem[0x002], each one cycle after its grant, with no cross-routing.
REQ-026 CPU asserts CpuRd and CpuWr together, CpuAddr=0x005, CpuWData=16'hBEEF. Required: MemWr=1, MemRd=0, and mem[0x005]=16'hBEEF.
REQ-027 Reset asserted the cycle after an Ext read grant. Required: ExtRValid stays 0 and all outputs equal their REQ-016/REQ-017 values.
REQ-028 With DATA_MEM_ARB_WRITE_PROTECT_EN defined, Ext writes 16'h00FF to 0x700. Required: ExtGnt=1, MemWr=0, ExtErr=1 the next cycle, and the memory is unchanged. Without the macro, mem[0x700]=16'h00FF.
